request_encoder_16to4: RTL and testbench
========================================

Name: request_encoder_16to4

Overview:
Converts 16 request lines back into a 4-bit index, the reverse of the 4-to-16 decoder. Each request line is latched into a pending register. The block emits one encoded index at a time over a valid/ready handshake and retires each pending bit once it is served. It sits between the per-line event sources and any consumer that wants a compact 4-bit event ID stream.

Parameters:
N_LINES, 16, number of request lines; fixed at 16 in this version.
IDX_W, 4, index width; must equal clog2(N_LINES).
ROUND_ROBIN, 0, 0 = fixed priority (lowest index wins); 1 = rotating priority starting after the last issued index.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
enable  input  1  1 = sample req; 0 = req ignored (pending still drains)
req  input  16  request lines, sampled every clock, level or pulse
y  output  4  encoded index of the issued request; 0 when valid=0
valid  output  1  y holds an issued request
ready  input  1  consumer accepts y this cycle when valid=1
pending  output  16  latched, not-yet-issued requests
overflow  output  1  one-cycle pulse: a request arrived for a line already pending

Behaviour:
- Clock and reset:
  - One clock (clk). Reset is synchronous and active-low (rst_n).
  - rst_n=0 at a rising edge clears pending, y, valid and overflow to 0 and sets last_idx to 15.
  - Reset mid-handshake discards the held index and all pending bits. No partial state survives.
- Request masking: req_en = req & {16{enable}}.
- Slot free (take) when valid=0, or when valid=1 and ready=1. ready is ignored when valid=0.
- Pick: computed combinationally from the registered pending only. Incoming req is not bypassed.
  - Fixed mode: lowest set bit.
  - RR mode: first set bit scanning last_idx+1, last_idx+2, ... with wrap from 15 to 0.
- take_mask: one-hot of the pick if take=1 and pending!=0, otherwise 0.
- Each rising edge, when not in reset:
  - pending <= (pending & ~take_mask) | req_en.
  - If take and pending!=0: y <= pick, valid <= 1, last_idx <= pick.
  - If take and pending==0: valid <= 0, y <= 0.
  - If not take: y and valid hold. The output is stable while valid=1 and ready=0.
  - overflow <= |(req_en & pending & ~take_mask).
- Latency:
  - req sampled at edge t0 sets pending after t0; valid rises after t0+1.
  - Back-to-back issue with ready held at 1: one index per clock.
- Simultaneous events:
  - A req on the bit being taken the same cycle re-sets that pending bit. This is not an overflow.
  - A req on the line currently held in y (valid=1) sets its pending bit normally. This is not an overflow.
- Boundaries:
  - pending all-zero with take: valid drops the next cycle.
  - pending all-ones: 16 consecutive issues with ready=1, in order 0..15. RR order is the same from reset.
  - RR wrap: last_idx=15 searches from 0.
  - enable=0: no new bits are set and overflow stays 0; existing pending bits still issue.
- Width rules:
  - y is the 4-bit binary index; bit 15 gives 4'hF.
  - last_idx is IDX_W bits and wraps naturally modulo 16.

Decomposition:
- Shared package (encdec_pkg):
  - N_LINES=16 and IDX_W=4 constants.
  - idx_t (logic [3:0]) and line_vec_t (logic [15:0]) typedefs.
  - The same package is used by the existing decoder.
- Sub-module: find_first_16. Purely combinational.
  - Inputs: vec[15:0] and start[3:0].
  - Outputs: idx[3:0] and found.
  - Rotate vec right by start, take the lowest set bit, then add start modulo 16.
  - Fixed mode ties start to 0; RR mode drives start = last_idx+1.

Test Plan:
1. Reset then idle: rst_n=0 for 2 clocks, req=0. Expect y=0, valid=0, pending=0, overflow=0. Hold rst_n=1 for 5 clocks: outputs unchanged.
2. Single request: enable=1, req=16'h0080 for one clock, ready=1. Expect pending=16'h0080 after edge 1. Expect valid=1, y=4'd7 after edge 2. Expect valid=0 after edge 3.
3. Fixed priority with backpressure: req=16'h8421 for one clock, ready=0 for 4 clocks, then 1.
   - Expect y=0 held with valid=1 while stalled.
   - Then expect y=5, 10, 15 on consecutive cycles, followed by valid=0.
4. Round-robin (ROUND_ROBIN=1): req=16'hFFFF every cycle, ready=1. Expect y sequence 0,1,...,15,0,1 with no repeats before wrap.
5. Overflow and enable:
   - req=16'h0004 for one clock, then again with ready=0 and valid holding another line. Expect a single overflow pulse.
   - enable=0 with req=16'hFFFF: expect no pending change and overflow=0.
6. Reset mid-operation: pending=16'h00F0 and valid=1 with y=4. Pulse rst_n=0 for one clock. Expect pending=0, valid=0, y=0 on the next edge, and RR restarting from index 0.

Source files
------------

// File: rtl/encdec_pkg.sv
// rtl/encdec_pkg.sv - shared constants and types for the 16-line encoder/decoder pair
package encdec_pkg;
  localparam int N_LINES = 16;
  localparam int IDX_W   = 4;

  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [N_LINES-1:0] line_vec_t;
endpackage

// File: rtl/find_first_16.sv
// rtl/find_first_16.sv - first set bit of a 16-bit vector, scanning upward from start with wrap
module find_first_16
  import encdec_pkg::*;
(
  input  line_vec_t vec,
  input  idx_t      start,
  output idx_t      idx,
  output logic      found
);

  logic [2*N_LINES-1:0] dbl;
  line_vec_t            rot;
  idx_t                 low;

  always_comb begin
    // rot[i] = vec[(i + start) mod 16], so the lowest set bit of rot is the first hit at or after start
    dbl   = {vec, vec} >> start;
    rot   = dbl[N_LINES-1:0];
    low   = '0;
    found = 1'b0;
    for (int i = N_LINES - 1; i >= 0; i--) begin
      if (rot[i]) begin
        low   = idx_t'(i);
        found = 1'b1;
      end
    end
    idx = low + start;
  end

endmodule

// File: rtl/request_encoder_16to4.sv
// rtl/request_encoder_16to4.sv - latches 16 request lines and issues them as 4-bit indices over valid/ready
module request_encoder_16to4
  import encdec_pkg::*;
#(
  parameter int ROUND_ROBIN = 0
)
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      enable,
  input  line_vec_t req,
  output idx_t      y,
  output logic      valid,
  input  logic      ready,
  output line_vec_t pending,
  output logic      overflow
);

  line_vec_t req_en;
  line_vec_t take_mask;
  idx_t      last_idx;
  idx_t      start;
  idx_t      pick;
  logic      found;
  logic      take;

  assign req_en = req & {N_LINES{enable}};
  assign take   = !valid || ready;
  assign start  = (ROUND_ROBIN != 0) ? idx_t'(last_idx + 4'd1) : '0;

  find_first_16 u_find_first (
    .vec   (pending),
    .start (start),
    .idx   (pick),
    .found (found)
  );

  always_comb begin
    take_mask = '0;
    if (take && found) begin
      take_mask[pick] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending  <= '0;
      y        <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      last_idx <= idx_t'(N_LINES - 1);
    end else begin
      pending  <= (pending & ~take_mask) | req_en;
      // a re-request of the bit being retired this cycle is not a collision
      overflow <= |(req_en & pending & ~take_mask);
      if (take) begin
        if (found) begin
          y        <= pick;
          valid    <= 1'b1;
          last_idx <= pick;
        end else begin
          y     <= '0;
          valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_request_encoder_16to4.sv
// tb/tb_request_encoder_16to4.sv - directed self-checking bench for fixed and round-robin encoders
module tb_request_encoder_16to4;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] req;
  logic        ready;

  logic [3:0]  fx_y;
  logic        fx_valid;
  logic [15:0] fx_pending;
  logic        fx_overflow;

  logic [3:0]  rr_y;
  logic        rr_valid;
  logic [15:0] rr_pending;
  logic        rr_overflow;

  int n_tests;
  int n_failed;

  request_encoder_16to4 #(.ROUND_ROBIN(0)) dut_fx (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .req      (req),
    .y        (fx_y),
    .valid    (fx_valid),
    .ready    (ready),
    .pending  (fx_pending),
    .overflow (fx_overflow)
  );

  request_encoder_16to4 #(.ROUND_ROBIN(1)) dut_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .req      (req),
    .y        (rr_y),
    .valid    (rr_valid),
    .ready    (ready),
    .pending  (rr_pending),
    .overflow (rr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests  = 0;
    n_failed = 0;
    rst_n    = 1'b0;
    enable   = 1'b1;
    req      = '0;
    ready    = 1'b1;

    // 1: reset then idle
    tick();
    tick();
    check("rst_y",        32'(fx_y),        32'h0);
    check("rst_valid",    32'(fx_valid),    32'h0);
    check("rst_pending",  32'(fx_pending),  32'h0);
    check("rst_overflow", 32'(fx_overflow), 32'h0);
    check("rst_rr_pend",  32'(rr_pending),  32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_valid",   32'(fx_valid),   32'h0);
      check("idle_pending", 32'(fx_pending), 32'h0);
    end

    // 2: single request on line 7
    req = 16'h0080;
    tick();
    req = '0;
    check("single_pend", 32'(fx_pending), 32'h0080);
    check("single_nv",   32'(fx_valid),   32'h0);
    tick();
    check("single_valid", 32'(fx_valid),   32'h1);
    check("single_y",     32'(fx_y),       32'h7);
    check("single_clr",   32'(fx_pending), 32'h0);
    tick();
    check("single_drop", 32'(fx_valid), 32'h0);
    check("single_y0",   32'(fx_y),     32'h0);

    // 3: fixed priority with backpressure
    ready = 1'b0;
    req   = 16'h8421;
    tick();
    req = '0;
    check("bp_pend", 32'(fx_pending), 32'h8421);
    tick();
    check("bp_first_y", 32'(fx_y),       32'h0);
    check("bp_first_v", 32'(fx_valid),   32'h1);
    check("bp_rest",    32'(fx_pending), 32'h8420);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_y", 32'(fx_y),     32'h0);
      check("bp_hold_v", 32'(fx_valid), 32'h1);
    end
    ready = 1'b1;
    tick();
    check("bp_y5", 32'(fx_y), 32'd5);
    tick();
    check("bp_y10", 32'(fx_y), 32'd10);
    tick();
    check("bp_y15", 32'(fx_y),     32'd15);
    check("bp_v15", 32'(fx_valid), 32'h1);
    tick();
    check("bp_end", 32'(fx_valid), 32'h0);

    // 4: round-robin sweep from reset with every line requesting
    do_reset();
    ready = 1'b1;
    req   = 16'hFFFF;
    tick();
    check("rr_pend", 32'(rr_pending), 32'hFFFF);
    for (int k = 0; k < 18; k++) begin
      tick();
      check("rr_seq_y", 32'(rr_y),     32'(k % 16));
      check("rr_seq_v", 32'(rr_valid), 32'h1);
      check("fx_fix_y", 32'(fx_y),     32'h0);
    end

    // 5: overflow and enable
    do_reset();
    ready = 1'b0;
    req   = 16'h0001;
    tick();
    req = 16'h0004;
    tick();
    check("ov_hold_y", 32'(fx_y),        32'h0);
    check("ov_pend",   32'(fx_pending),  32'h0004);
    check("ov_none",   32'(fx_overflow), 32'h0);
    tick();
    check("ov_pulse", 32'(fx_overflow), 32'h1);
    req   = 16'h0004;
    ready = 1'b1;
    tick();
    check("ov_retake_y",  32'(fx_y),        32'd2);
    check("ov_retake_p",  32'(fx_pending),  32'h0004);
    check("ov_retake_ov", 32'(fx_overflow), 32'h0);
    enable = 1'b0;
    req    = 16'hFFFF;
    tick();
    check("en_y",    32'(fx_y),        32'd2);
    check("en_pend", 32'(fx_pending),  32'h0);
    check("en_ov",   32'(fx_overflow), 32'h0);
    tick();
    check("en_drop", 32'(fx_valid),    32'h0);
    check("en_ov2",  32'(fx_overflow), 32'h0);
    check("en_rr",   32'(rr_pending),  32'h0);
    enable = 1'b1;

    // 6: reset mid-operation, round-robin restarts at line 0
    do_reset();
    ready = 1'b0;
    req   = 16'h00F0;
    tick();
    tick();
    req = '0;
    check("mid_pend", 32'(rr_pending), 32'h00F0);
    check("mid_y",    32'(rr_y),       32'd4);
    check("mid_v",    32'(rr_valid),   32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_pend", 32'(rr_pending),  32'h0);
    check("mid_rst_v",    32'(rr_valid),    32'h0);
    check("mid_rst_y",    32'(rr_y),        32'h0);
    check("mid_rst_ov",   32'(rr_overflow), 32'h0);
    ready = 1'b1;
    req   = 16'h8001;
    tick();
    req = '0;
    tick();
    check("restart_y0", 32'(rr_y), 32'd0);
    tick();
    check("restart_y15", 32'(rr_y), 32'd15);
    tick();
    check("restart_end", 32'(rr_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
